// File: rtl/instr_mem_ld_pkg.sv
// Shared types and defaults for the instruction memory loader.
// Holds the controller state encoding and the default NOP word.
package instr_mem_ld_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2
  } state_t;

  localparam int DEF_DATA_W = 32;
  localparam logic [DEF_DATA_W-1:0] DEF_NOP_WORD = '0;

endpackage

// File: rtl/instr_ram_1r1w.sv
// Program storage: DEPTH x DATA_W, synchronous write, registered read, no reset.
// Latency: read data valid the cycle after re; rdata holds while re is low.
// Backpressure: none; the caller gates re and we.
module instr_ram_1r1w #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/instr_mem_ld.sv
// Instruction memory with a streaming program loader and a one-deep fetch port.
// Latency: fetch granted in cycle N responds in N+1; ld_done one cycle after the final write.
// Backpressure: a held response blocks new grants until instr_ready; ld_start preempts fetches.
module instr_mem_ld
  import instr_mem_ld_pkg::*;
#(
  parameter int                 DATA_W   = DEF_DATA_W,
  parameter int                 ADDR_W   = 8,
  parameter int                 DEPTH    = 256,
  parameter logic [DATA_W-1:0]  NOP_WORD = DATA_W'(DEF_NOP_WORD)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_done,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_gnt,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr_rdata,
  output logic              instr_fault,
  output logic [1:0]        state_o
);

  localparam int RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = ADDR_W + 1;

  state_t state, state_nxt;

  logic [ADDR_W-1:0] wptr;
  logic [CNT_W-1:0]  cnt;
  logic              load_go;
  logic              wr_en;
  logic              fetch_en;
  logic              load_end;
  logic              addr_oob;
  logic              done_q;
  logic              rvalid_q;
  logic              fault_q;
  logic [DATA_W-1:0] ram_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      EMPTY:   if (ld_start) state_nxt = LOAD;
      LOAD:    if (load_end) state_nxt = RUN;
      RUN:     if (ld_start) state_nxt = LOAD;
      default: state_nxt = EMPTY;
    endcase
  end

  // ld_start is only honoured outside LOAD; fetches stand down for it in RUN.
  always_comb begin
    load_go  = 1'b0;
    wr_en    = 1'b0;
    fetch_en = 1'b0;
    case (state)
      EMPTY: load_go = ld_start;
      LOAD:  wr_en   = ld_valid;
      RUN: begin
        load_go  = ld_start;
        fetch_en = !ld_start;
      end
      default: ;
    endcase
  end

  // A write to the top word ends the load even without ld_last.
  assign load_end  = wr_en && (ld_last || (wptr == ADDR_W'(DEPTH - 1)));
  assign addr_oob  = ({1'b0, fetch_addr} >= cnt);
  assign fetch_gnt = fetch_req && fetch_en && (!rvalid_q || instr_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr   <= '0;
      cnt    <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= load_end;
      if (load_go) begin
        wptr <= '0;
        cnt  <= '0;
      end else if (wr_en) begin
        wptr <= wptr + ADDR_W'(1);
        cnt  <= cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q <= 1'b0;
      fault_q  <= 1'b0;
    end else if (load_go) begin
      rvalid_q <= 1'b0;
    end else if (fetch_gnt) begin
      rvalid_q <= 1'b1;
      fault_q  <= addr_oob;
    end else if (instr_ready) begin
      rvalid_q <= 1'b0;
    end
  end

  // Out-of-range fetches skip the RAM so stale storage never leaks out.
  instr_ram_1r1w #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (RAM_AW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wptr[RAM_AW-1:0]),
    .wdata (ld_data),
    .re    (fetch_gnt && !addr_oob),
    .raddr (fetch_addr[RAM_AW-1:0]),
    .rdata (ram_rdata)
  );

  assign ld_done     = done_q;
  assign instr_valid = rvalid_q;
  assign instr_fault = rvalid_q && fault_q;
  assign instr_rdata = (rvalid_q && !fault_q) ? ram_rdata : NOP_WORD;
  assign state_o     = state;

endmodule

// File: doc/instr_mem_ld.md
INSTR_MEM_LD -- requirements
Module: instr_mem_ld

Interface
REQ-001 Parameter DATA_W, default 32, instruction word width in bits.
REQ-002 Parameter ADDR_W, default 8, word-address width.
REQ-003 Parameter DEPTH, default 256, number of words; SHALL satisfy 2 <= DEPTH <= 2**ADDR_W.
REQ-004 Parameter NOP_WORD, default all-zero DATA_W, word returned for unloaded or out-of-range addresses.
REQ-005 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-006 clk  in  1  sole clock; all state changes on rising edge.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 ld_start  in  1  one-cycle pulse; begins a program load.
REQ-009 ld_valid  in  1  ld_data carries the next program word.
REQ-010 ld_data  in  DATA_W  program word.
REQ-011 ld_last  in  1  qualifies ld_valid; marks the final word.
REQ-012 ld_done  out  1  one-cycle pulse when a load completes.
REQ-013 fetch_req  in  1  fetch request.
REQ-014 fetch_addr  in  ADDR_W  word address of the fetch.
REQ-015 fetch_gnt  out  1  fetch accepted this cycle (combinational).
REQ-016 instr_valid  out  1  instr_rdata/instr_fault hold a response.
REQ-017 instr_ready  in  1  consumer accepts the response.
REQ-018 instr_rdata  out  DATA_W  fetched instruction.
REQ-019 instr_fault  out  1  response address was >= loaded word count.
REQ-020 state_o  out  2  current state encoding (EMPTY=0, LOAD=1, RUN=2).

Function
REQ-021 FSM states EMPTY, LOAD, RUN; EMPTY->LOAD and RUN->LOAD on ld_start; LOAD->RUN on a completing write; no other transitions.
REQ-022 On entering LOAD, write pointer and loaded count SHALL clear to 0.
REQ-023 In LOAD, each ld_valid cycle SHALL write ld_data at the pointer, then increment pointer and count.
REQ-024 A load SHALL complete on ld_valid&&ld_last or on the write to address DEPTH-1, whichever comes first; ld_done pulses the following cycle, with state RUN.
REQ-025 ld_valid outside LOAD, and ld_start while in LOAD, SHALL be ignored.
REQ-026 fetch_gnt = fetch_req && state==RUN && !ld_start && (!instr_valid || instr_ready).
REQ-027 Read latency SHALL be exactly one cycle: a grant in cycle N gives instr_valid=1 in cycle N+1.
REQ-028 If fetch_addr >= loaded count, response SHALL be NOP_WORD with instr_fault=1; otherwise stored word with instr_fault=0.
REQ-029 While instr_valid && !instr_ready, instr_rdata and instr_fault SHALL hold stable.
REQ-030 instr_valid SHALL clear after acceptance with no new grant in the same cycle; back-to-back grants give one response per cycle.
REQ-031 ld_start in RUN SHALL take priority over fetch_req and clear instr_valid in the next cycle, discarding any pending response.
REQ-032 Memory contents are not reset; words beyond loaded count are never returned.

Reset
REQ-033 While rst_n=0: state EMPTY, pointer and count 0, ld_done=0, instr_valid=0, instr_rdata=NOP_WORD, instr_fault=0, fetch_gnt=0.
REQ-034 Reset asserted mid-load or mid-fetch SHALL abandon the operation; after release, the block SHALL sit in EMPTY until ld_start.

Structure
REQ-035 Shared package SHALL hold the state enum (EMPTY/LOAD/RUN) and the default NOP_WORD constant.
REQ-036 Storage SHALL be one sub-module, instr_ram_1r1w: synchronous write, registered read, DEPTH x DATA_W, no reset.

Verification
REQ-037 Reset, pulse ld_start, load 0x20010003, 0x20020009, 0x00221020 (ld_last on third) -> ld_done one cycle after third write, state_o=2.
REQ-038 Fetch addr 0,1,2 back-to-back with instr_ready=1 -> 0x20010003, 0x20020009, 0x00221020 on consecutive cycles, fault=0.
REQ-039 Fetch addr 3 after the 3-word load -> instr_rdata=0x00000000, instr_fault=1.
REQ-040 Fetch addr 1 with instr_ready=0 for 4 cycles -> 0x20020009 held, fetch_gnt=0 throughout; gnt resumes on the acceptance cycle.
REQ-041 DEPTH=4: send 6 ld_valid words, no ld_last -> load completes after the 4th, words 5-6 ignored; fetch addr 3 returns 4th word.
REQ-042 rst_n low during the 2nd load word, then fetch_req=1 -> fetch_gnt=0, state_o=0 until a new load completes.
